// File: rtl/vga_offset_pkg.sv
// vga_offset_pkg
// Shared constants for the VGA offset bank: per-channel register offsets,
// CTRL bit positions and the FRAME_CNT word index.
package vga_offset_pkg;

  // Word offsets inside one channel's 4-word register window
  localparam logic [1:0] REG_SHADOW = 2'd0;
  localparam logic [1:0] REG_STEP   = 2'd1;
  localparam logic [1:0] REG_LIMIT  = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;

  // CTRL bit positions
  localparam int CTRL_AUTO_EN_BIT    = 0;  // RW
  localparam int CTRL_PENDING_BIT    = 1;  // RO
  localparam int CTRL_ACTIVE_SEL_BIT = 2;  // unused, reads 0

  // FRAME_CNT sits directly after the last channel window
  function automatic int frame_cnt_index(input int num_ch);
    return 4 * num_ch;
  endfunction

endpackage

// File: rtl/vga_offset_channel.sv
// vga_offset_channel
// One offset channel: SHADOW/STEP/LIMIT/AUTO_EN registers, the PENDING flag
// and the ACTIVE offset that is updated only on frame events.
// Ports:
//   clk, reset_n       clock, asynchronous active-low reset
//   frame_evt          one-cycle frame event pulse
//   wr_en, wr_off      write strobe for this channel and register offset
//   wr_data            write data (CTRL uses bit 0 only)
//   shadow/step/limit  register values for readback
//   active             current offset driven to the display
//   auto_en, pending   CTRL status bits
module vga_offset_channel
  import vga_offset_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             frame_evt,
  input  logic             wr_en,
  input  logic [1:0]       wr_off,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] shadow,
  output logic [WIDTH-1:0] step,
  output logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] active,
  output logic             auto_en,
  output logic             pending
);

  logic [WIDTH-1:0] shadow_reg;
  logic [WIDTH-1:0] step_reg;
  logic [WIDTH-1:0] limit_reg;
  logic [WIDTH-1:0] active_reg;
  logic             auto_en_reg;
  logic             pending_reg;

  // Auto-scroll: one extra bit keeps the carry so the limit compare is exact.
  // A single subtraction is enough because software keeps STEP < LIMIT.
  logic [WIDTH:0]   sum_next;
  logic [WIDTH-1:0] wrapped_next;

  assign sum_next = {1'b0, active_reg} + {1'b0, step_reg};

  always_comb begin
    wrapped_next = sum_next[WIDTH-1:0];
    if ((limit_reg != '0) && (sum_next >= {1'b0, limit_reg})) begin
      wrapped_next = WIDTH'(sum_next - {1'b0, limit_reg});
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow_reg  <= '0;
      step_reg    <= '0;
      limit_reg   <= '0;
      active_reg  <= '0;
      auto_en_reg <= 1'b0;
      pending_reg <= 1'b0;
    end else begin
      if (frame_evt) begin
        if (pending_reg) begin
          active_reg  <= shadow_reg;
          pending_reg <= 1'b0;
        end else if (auto_en_reg) begin
          active_reg <= wrapped_next;
        end
      end
      // Placed after the commit so that a SHADOW write landing on the frame
      // event keeps PENDING set; the commit above still sees the old SHADOW.
      if (wr_en) begin
        case (wr_off)
          REG_SHADOW: begin
            shadow_reg  <= wr_data;
            pending_reg <= 1'b1;
          end
          REG_STEP:  step_reg    <= wr_data;
          REG_LIMIT: limit_reg   <= wr_data;
          REG_CTRL:  auto_en_reg <= wr_data[CTRL_AUTO_EN_BIT];
          default: ;
        endcase
      end
    end
  end

  assign shadow  = shadow_reg;
  assign step    = step_reg;
  assign limit   = limit_reg;
  assign active  = active_reg;
  assign auto_en = auto_en_reg;
  assign pending = pending_reg;

endmodule

// File: rtl/vga_offset_bank.sv
// vga_offset_bank
// Avalon-MM bank of NUM_CH display offset channels whose active values only
// change on VGA frame boundaries (vsync_n falling edge).
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   address, chipselect,
//   write_n, writedata    Avalon-MM slave write side
//   readdata              combinational read data, zero wait states
//   vsync_n               VGA vertical sync, active-low, synchronous to clk
//   out_port              active offsets, channel c at [c*WIDTH +: WIDTH]
module vga_offset_bank
  import vga_offset_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [ADDR_W-1:0]       address,
  input  logic                    chipselect,
  input  logic                    write_n,
  input  logic [31:0]             writedata,
  output logic [31:0]             readdata,
  input  logic                    vsync_n,
  output logic [NUM_CH*WIDTH-1:0] out_port
);

  localparam int FRAME_IDX = frame_cnt_index(NUM_CH);

  logic              wr_en;
  logic [ADDR_W-3:0] ch_idx;
  logic [1:0]        reg_off;
  logic [WIDTH-1:0]  wr_data;
  logic              unused_wdata;

  assign wr_en        = chipselect & ~write_n;
  assign ch_idx       = address[ADDR_W-1:2];
  assign reg_off      = address[1:0];
  assign wr_data      = writedata[WIDTH-1:0];
  assign unused_wdata = ^writedata;

  // Frame event detection. vsync_reg holds the previous vsync_n sample and
  // resets to 1; armed_reg masks the first post-reset sample so a vsync_n
  // that is already low when reset releases does not look like an edge.
  logic        vsync_reg;
  logic        armed_reg;
  logic        frame_evt_reg;
  logic [31:0] frame_cnt_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vsync_reg     <= 1'b1;
      armed_reg     <= 1'b0;
      frame_evt_reg <= 1'b0;
      frame_cnt_reg <= '0;
    end else begin
      vsync_reg     <= vsync_n;
      armed_reg     <= 1'b1;
      frame_evt_reg <= armed_reg & vsync_reg & ~vsync_n;
      if (frame_evt_reg) begin
        frame_cnt_reg <= frame_cnt_reg + 32'd1;
      end
    end
  end

  logic [WIDTH-1:0] shadow_arr [NUM_CH];
  logic [WIDTH-1:0] step_arr   [NUM_CH];
  logic [WIDTH-1:0] limit_arr  [NUM_CH];
  logic [WIDTH-1:0] active_arr [NUM_CH];
  logic [NUM_CH-1:0] auto_arr;
  logic [NUM_CH-1:0] pend_arr;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic ch_wr;
    // ch_idx equal to a real channel number implies address < FRAME_IDX
    assign ch_wr = wr_en && (ch_idx == (ADDR_W-2)'(gi));

    vga_offset_channel #(
      .WIDTH(WIDTH)
    ) u_ch (
      .clk       (clk),
      .reset_n   (reset_n),
      .frame_evt (frame_evt_reg),
      .wr_en     (ch_wr),
      .wr_off    (reg_off),
      .wr_data   (wr_data),
      .shadow    (shadow_arr[gi]),
      .step      (step_arr[gi]),
      .limit     (limit_arr[gi]),
      .active    (active_arr[gi]),
      .auto_en   (auto_arr[gi]),
      .pending   (pend_arr[gi])
    );

    assign out_port[gi*WIDTH +: WIDTH] = active_arr[gi];
  end

  always_comb begin
    readdata = '0;
    if (address == ADDR_W'(FRAME_IDX)) begin
      readdata = frame_cnt_reg;
    end
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_idx == (ADDR_W-2)'(c)) begin
        case (reg_off)
          REG_SHADOW: readdata = 32'(shadow_arr[c]);
          REG_STEP:   readdata = 32'(step_arr[c]);
          REG_LIMIT:  readdata = 32'(limit_arr[c]);
          REG_CTRL: begin
            readdata[CTRL_AUTO_EN_BIT] = auto_arr[c];
            readdata[CTRL_PENDING_BIT] = pend_arr[c];
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vga_offset_bank.sv
// tb_vga_offset_bank
// Self-checking bench: directed vector table, hand-written corner sequences
// (commit/write collision, frame counter, reset with vsync low) and a
// randomized phase checked against a behavioural model of the register bank.
module tb_vga_offset_bank;

  localparam int NCH = 2;
  localparam int W   = 16;
  localparam int AW  = 4;
  localparam int FC_ADDR = 4 * NCH;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [AW-1:0]     address = '0;
  logic              chipselect = 1'b0;
  logic              write_n = 1'b1;
  logic [31:0]       writedata = '0;
  logic [31:0]       readdata;
  logic              vsync_n = 1'b1;
  logic [NCH*W-1:0]  out_port;

  int total = 0;
  int bad   = 0;

  vga_offset_bank #(.NUM_CH(NCH), .WIDTH(W), .ADDR_W(AW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .vsync_n    (vsync_n),
    .out_port   (out_port)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  longint m_shadow [NCH];
  longint m_step   [NCH];
  longint m_limit  [NCH];
  longint m_active [NCH];
  bit     m_auto   [NCH];
  bit     m_pend   [NCH];
  longint m_fcnt;

  function automatic void model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_shadow[c] = 0; m_step[c] = 0; m_limit[c] = 0; m_active[c] = 0;
      m_auto[c] = 0; m_pend[c] = 0;
    end
    m_fcnt = 0;
  endfunction

  function automatic void model_write(input int a, input logic [31:0] d);
    longint v;
    v = longint'(d) % (64'd1 << W);
    if (a < 4 * NCH) begin
      case (a % 4)
        0: begin m_shadow[a/4] = v; m_pend[a/4] = 1; end
        1: m_step[a/4]  = v;
        2: m_limit[a/4] = v;
        default: m_auto[a/4] = d[0];
      endcase
    end
  endfunction

  function automatic void model_frame();
    longint s;
    m_fcnt = (m_fcnt + 1) % (64'd1 << 32);
    for (int c = 0; c < NCH; c++) begin
      if (m_pend[c]) begin
        m_active[c] = m_shadow[c];
        m_pend[c] = 0;
      end else if (m_auto[c]) begin
        s = m_active[c] + m_step[c];
        if (m_limit[c] != 0 && s >= m_limit[c]) s = s - m_limit[c];
        m_active[c] = s % (64'd1 << W);
      end
    end
  endfunction

  function automatic logic [31:0] model_read(input int a);
    if (a == FC_ADDR) return 32'(m_fcnt);
    if (a > FC_ADDR) return 32'd0;
    case (a % 4)
      0: return 32'(m_shadow[a/4]);
      1: return 32'(m_step[a/4]);
      2: return 32'(m_limit[a/4]);
      default: return {30'd0, m_pend[a/4], m_auto[a/4]};
    endcase
  endfunction

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", name, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", name, got);
    end
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    @(negedge clk);
    address = AW'(a); writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input int a, output logic [31:0] d);
    @(negedge clk);
    address = AW'(a);
    #1 d = readdata;
  endtask

  task automatic frame_pulse();
    @(negedge clk) vsync_n = 1'b0;
    @(negedge clk);
    @(negedge clk) vsync_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk) reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    model_reset();
  endtask

  function automatic logic [31:0] chan(input int c);
    return 32'(out_port[c*W +: W]);
  endfunction

  // ---------------- directed vector table ----------------
  localparam int OP_W = 0, OP_R = 1, OP_F = 2, OP_P = 3;
  typedef struct {
    int          op;
    int          addr;
    logic [31:0] data;
    string       name;
  } vec_t;
  vec_t tbl[$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    int r, a;
    logic [31:0] v;

    tbl.push_back('{OP_W, 0, 32'h0123, "w"});
    tbl.push_back('{OP_P, 0, 32'h0, "shadow_no_vsync_ch0"});
    tbl.push_back('{OP_R, 3, 32'h2, "ctrl0_pending"});
    tbl.push_back('{OP_F, 0, 32'h0, "f"});
    tbl.push_back('{OP_P, 0, 32'h0123, "commit_ch0"});
    tbl.push_back('{OP_R, 3, 32'h0, "ctrl0_cleared"});
    tbl.push_back('{OP_R, 0, 32'h0123, "shadow0_read"});
    tbl.push_back('{OP_W, 6, 32'd480, "w"});
    tbl.push_back('{OP_W, 5, 32'd4, "w"});
    tbl.push_back('{OP_W, 4, 32'd476, "w"});
    tbl.push_back('{OP_W, 7, 32'd1, "w"});
    tbl.push_back('{OP_R, 7, 32'h3, "ctrl1_pend_auto"});
    tbl.push_back('{OP_F, 0, 32'h0, "f"});
    tbl.push_back('{OP_P, 1, 32'd476, "ch1_frame1"});
    tbl.push_back('{OP_F, 0, 32'h0, "f"});
    tbl.push_back('{OP_P, 1, 32'd0, "ch1_frame2_wrap"});
    tbl.push_back('{OP_F, 0, 32'h0, "f"});
    tbl.push_back('{OP_P, 1, 32'd4, "ch1_frame3"});
    tbl.push_back('{OP_P, 0, 32'h0123, "ch0_holds"});
    tbl.push_back('{OP_R, 5, 32'd4, "step1_read"});
    tbl.push_back('{OP_R, 6, 32'd480, "limit1_read"});
    tbl.push_back('{OP_W, 2, 32'h0, "w"});
    tbl.push_back('{OP_W, 1, 32'hFFFF, "w"});
    tbl.push_back('{OP_W, 0, 32'h0002, "w"});
    tbl.push_back('{OP_W, 3, 32'h1, "w"});
    tbl.push_back('{OP_F, 0, 32'h0, "f"});
    tbl.push_back('{OP_P, 0, 32'h0002, "ch0_load2"});
    tbl.push_back('{OP_F, 0, 32'h0, "f"});
    tbl.push_back('{OP_P, 0, 32'h0001, "ch0_limit0_modwrap"});
    tbl.push_back('{OP_P, 1, 32'd12, "ch1_auto_run"});
    tbl.push_back('{OP_W, 3, 32'hFFFFFFFE, "w"});
    tbl.push_back('{OP_R, 3, 32'h0, "ctrl_reserved_ignored"});
    tbl.push_back('{OP_W, 1, 32'hABCD0005, "w"});
    tbl.push_back('{OP_R, 1, 32'h5, "step_upper_masked"});
    tbl.push_back('{OP_W, 8, 32'h1234, "w"});
    tbl.push_back('{OP_R, 8, 32'd6, "frame_cnt_ro"});
    tbl.push_back('{OP_R, 9, 32'h0, "addr9_zero"});
    tbl.push_back('{OP_W, 12, 32'hFFFF, "w"});
    tbl.push_back('{OP_R, 12, 32'h0, "addr12_zero"});
    tbl.push_back('{OP_F, 0, 32'h0, "f"});
    tbl.push_back('{OP_P, 0, 32'h0001, "ch0_no_auto_holds"});
    tbl.push_back('{OP_P, 1, 32'd16, "ch1_auto_16"});

    // reset state
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    @(negedge clk);
    chk("reset_out_port_lo", out_port[31:0], 32'h0);
    for (int i = 0; i <= FC_ADDR; i++) begin
      rd(i, d);
      chk($sformatf("reset_read_%0d", i), d, 32'h0);
    end

    // table
    foreach (tbl[i]) begin
      case (tbl[i].op)
        OP_W: wr(tbl[i].addr, tbl[i].data);
        OP_R: begin rd(tbl[i].addr, d); chk(tbl[i].name, d, tbl[i].data); end
        OP_F: frame_pulse();
        default: begin @(negedge clk); chk(tbl[i].name, chan(tbl[i].addr), tbl[i].data); end
      endcase
    end

    // SHADOW write landing on the frame-event cycle
    do_reset();
    wr(0, 32'h0008);
    @(negedge clk) vsync_n = 1'b0;
    @(negedge clk);   // frame event is high during this cycle
    address = AW'(0); writedata = 32'h0010; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1; vsync_n = 1'b1;
    @(negedge clk);
    chk("collide_active_old", chan(0), 32'h0008);
    rd(3, d);
    chk("collide_pending_kept", d, 32'h2);
    rd(0, d);
    chk("collide_shadow_new", d, 32'h0010);
    frame_pulse();
    chk("collide_next_frame", chan(0), 32'h0010);

    // Frame counter over five frames
    do_reset();
    for (int i = 0; i < 5; i++) frame_pulse();
    rd(FC_ADDR, d);
    chk("frame_cnt_5", d, 32'd5);
    rd(FC_ADDR + 1, d);
    chk("above_frame_cnt_zero", d, 32'd0);

    // Reset with PENDING set and vsync_n low, released with vsync_n low
    do_reset();
    wr(0, 32'h0055);
    @(negedge clk) vsync_n = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("async_reset_pending", {30'd0, readdata[1:0]}, 32'h0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    repeat (5) @(negedge clk);
    chk("rst_vsync_low_out", out_port, 32'h0);
    rd(FC_ADDR, d);
    chk("rst_vsync_low_fcnt", d, 32'h0);
    rd(3, d);
    chk("rst_vsync_low_ctrl", d, 32'h0);
    @(negedge clk) vsync_n = 1'b1;
    frame_pulse();
    chk("rst_pending_discarded", chan(0), 32'h0);
    rd(FC_ADDR, d);
    chk("rst_then_frame_cnt", d, 32'h1);

    // Randomized phase against the model
    do_reset();
    for (int it = 0; it < 400; it++) begin
      r = $urandom_range(0, 9);
      if (r <= 3) begin
        a = $urandom_range(0, 15);
        v = $urandom;
        if (a < FC_ADDR && (a % 4) == 2 && $urandom_range(0, 3) == 0) v = 32'h0;
        wr(a, v);
        model_write(a, v);
      end else if (r <= 6) begin
        a = $urandom_range(0, 15);
        rd(a, d);
        chk($sformatf("rand_read_a%0d", a), d, model_read(a));
      end else if (r == 7) begin
        frame_pulse();
        model_frame();
      end else begin
        @(negedge clk);
        for (int c = 0; c < NCH; c++)
          chk($sformatf("rand_out_ch%0d", c), chan(c), 32'(m_active[c]));
      end
    end
    rd(FC_ADDR, d);
    chk("rand_frame_cnt", d, 32'(m_fcnt));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
